// File: rtl/core_mem_arb_if.sv
// Bundle of the IFU, LSU and memory-bus handshakes around the core memory arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface core_mem_arb_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int WMASK_W = DATA_W / 8
);
    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic [ADDR_W-1:0]  ifu_req_addr;
    logic               ifu_flush;
    logic               ifu_rsp_valid;
    logic [DATA_W-1:0]  ifu_rsp_data;

    logic               lsu_req_valid;
    logic               lsu_req_ready;
    logic [ADDR_W-1:0]  lsu_req_addr;
    logic               lsu_req_wen;
    logic [DATA_W-1:0]  lsu_req_wdata;
    logic [WMASK_W-1:0] lsu_req_wmask;
    logic               lsu_rsp_valid;
    logic [DATA_W-1:0]  lsu_rsp_data;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_req_wen;
    logic [DATA_W-1:0]  mem_req_wdata;
    logic [WMASK_W-1:0] mem_req_wmask;
    logic               mem_rsp_valid;
    logic [DATA_W-1:0]  mem_rsp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_flush,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_flush,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/core_mem_arb.sv
// Shares the single core memory port between IFU fetches and LSU accesses:
// LSU-first priority with a starvation guard, one outstanding transaction, flush-aware IFU returns.
module core_mem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    core_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    state_t     state;
    owner_t     owner;
    logic [3:0] starve_cnt;
    logic       drop;

    logic   ifu_eff;
    logic   sel_valid;
    owner_t sel_owner;
    logic   handshake;
    logic   rsp_hit;
    logic   ifu_strobe;
    logic   lsu_strobe;

    // Pick who drives the bus this cycle; all strobes are held low while reset is asserted.
    always_comb begin
        ifu_eff   = bus.ifu_req_valid & ~bus.ifu_flush;
        sel_valid = 1'b0;
        sel_owner = owner;
        case (state)
            IDLE: begin
                if (bus.lsu_req_valid && starve_cnt != CNT_MAX) begin
                    sel_valid = 1'b1;
                    sel_owner = OWN_LSU;
                end else if (ifu_eff) begin
                    sel_valid = 1'b1;
                    sel_owner = OWN_IFU;
                end else if (bus.lsu_req_valid) begin
                    sel_valid = 1'b1;
                    sel_owner = OWN_LSU;
                end
            end
            REQ: begin
                sel_valid = 1'b1;
                sel_owner = owner;
            end
            default: sel_valid = 1'b0;
        endcase
        if (!rst_n) begin
            sel_valid = 1'b0;
        end
        handshake  = sel_valid & bus.mem_req_ready;
        rsp_hit    = rst_n & (state == RSP) & bus.mem_rsp_valid;
        ifu_strobe = rsp_hit & (owner == OWN_IFU) & ~drop & ~bus.ifu_flush;
        lsu_strobe = rsp_hit & (owner == OWN_LSU);
    end

    assign bus.mem_req_valid = sel_valid;
    assign bus.ifu_req_ready = handshake & (sel_owner == OWN_IFU);
    assign bus.lsu_req_ready = handshake & (sel_owner == OWN_LSU);
    assign bus.mem_req_addr  = !sel_valid ? '0 :
                               (sel_owner == OWN_LSU) ? bus.lsu_req_addr : bus.ifu_req_addr;
    assign bus.mem_req_wen   = sel_valid & (sel_owner == OWN_LSU) & bus.lsu_req_wen;
    assign bus.mem_req_wdata = (sel_valid && sel_owner == OWN_LSU) ? bus.lsu_req_wdata : '0;
    assign bus.mem_req_wmask = (sel_valid && sel_owner == OWN_LSU) ? bus.lsu_req_wmask : '0;
    assign bus.ifu_rsp_valid = ifu_strobe;
    assign bus.lsu_rsp_valid = lsu_strobe;
    assign bus.ifu_rsp_data  = ifu_strobe ? bus.mem_rsp_data : '0;
    assign bus.lsu_rsp_data  = lsu_strobe ? bus.mem_rsp_data : '0;

    // Owner lock, starvation count and the flush drop flag; a response clears drop even under flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_LSU;
            starve_cnt <= '0;
            drop       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner <= sel_owner;
                        state <= bus.mem_req_ready ? RSP : REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (bus.mem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (handshake) begin
                if (sel_owner == OWN_IFU) begin
                    starve_cnt <= '0;
                end else if (ifu_eff && starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            if (rsp_hit) begin
                drop <= 1'b0;
            end else if (state != IDLE && owner == OWN_IFU && bus.ifu_flush) begin
                drop <= 1'b1;
            end
        end
    end
endmodule
